// File: rtl/hbm_grp_rd_ctrl_if.sv
// hbm_grp_rd_ctrl_if: AXI4 read address/data handshake bundle for one HBM port.
interface hbm_grp_rd_ctrl_if #(parameter int ADDR_W = 33);
    logic              ar_valid;
    logic              ar_ready;
    logic [ADDR_W-1:0] ar_addr;
    logic [7:0]        ar_len;
    logic              r_valid;
    logic              r_last;
    logic              r_ready;
    modport master(output ar_valid, ar_addr, ar_len, r_ready, input ar_ready, r_valid, r_last);
    modport slave(input ar_valid, ar_addr, ar_len, r_ready, output ar_ready, r_valid, r_last);
endinterface

// File: rtl/hbm_grp_rd_ctrl.sv
// hbm_grp_rd_ctrl: per-group HBM read-burst controller armed by launch, released by start_load_all.
module hbm_grp_rd_ctrl #(
    parameter int ADDR_W     = 33,
    parameter int BURST_LEN  = 64,
    parameter int BEAT_BYTES = 64,
    parameter int MAX_OUT    = 8,
    parameter int NB_W       = 16
) (
    input  logic                sclk,
    input  logic                rst_n,
    input  logic                launch,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [NB_W-1:0]     num_burst,
    output logic                start_load,
    input  logic                start_load_all,
    hbm_grp_rd_ctrl_if.master   axi,
    output logic                busy,
    output logic                done,
    output logic [31:0]         beat_cnt,
    output logic                err
);
    localparam int OW = $clog2(MAX_OUT) + 1;
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BURST_LEN * BEAT_BYTES);

    typedef enum logic [2:0] {IDLE, ARM, WAIT_ALL, RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic              launch_d, arm, ar_hs, beat, last_acc;
    logic [ADDR_W-1:0] addr;
    logic [NB_W-1:0]   nb, issued, completed;
    logic [OW-1:0]     outstanding;
    logic [BW-1:0]     idx;

    assign arm          = launch & ~launch_d;
    assign busy         = state != IDLE;
    assign start_load   = state == ARM;
    assign done         = state == DONE;
    assign axi.r_ready  = state == RUN || state == DRAIN;
    assign axi.ar_valid = state == RUN && issued < nb && outstanding < OW'(MAX_OUT);
    assign axi.ar_addr  = addr;
    assign axi.ar_len   = busy ? 8'(BURST_LEN - 1) : 8'd0;
    assign ar_hs        = axi.ar_valid & axi.ar_ready;
    assign beat         = axi.r_valid & axi.r_ready;
    assign last_acc     = beat & axi.r_last;

    always_ff @(posedge sclk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // DRAIN looks at the completion count including this cycle's r_last so done follows it by one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = arm ? ARM : IDLE;
            ARM:      state_nxt = WAIT_ALL;
            WAIT_ALL: state_nxt = !start_load_all ? WAIT_ALL : (nb == '0) ? DONE : RUN;
            RUN:      state_nxt = (ar_hs && issued + NB_W'(1) == nb) ? DRAIN : RUN;
            DRAIN:    state_nxt = (completed + NB_W'(last_acc) == nb) ? DONE : DRAIN;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            launch_d    <= 1'b0;
            addr        <= '0;
            nb          <= '0;
            issued      <= '0;
            completed   <= '0;
            outstanding <= '0;
            idx         <= '0;
            beat_cnt    <= '0;
            err         <= 1'b0;
        end else begin
            launch_d <= launch;
            if (state == IDLE && arm) begin
                addr        <= {base_addr[ADDR_W-1:12], 12'h000};
                nb          <= num_burst;
                issued      <= '0;
                completed   <= '0;
                outstanding <= '0;
                idx         <= '0;
                beat_cnt    <= '0;
                err         <= 1'b0;
            end else begin
                if (ar_hs) begin
                    addr   <= addr + STEP;
                    issued <= issued + NB_W'(1);
                end
                if (beat) begin
                    beat_cnt <= beat_cnt + 32'd1;
                    idx      <= axi.r_last ? '0 : idx + BW'(1);
                    err      <= err | (axi.r_last != (idx == BW'(BURST_LEN - 1)));
                end
                if (last_acc) completed <= completed + NB_W'(1);
                outstanding <= outstanding + OW'(ar_hs) - OW'(last_acc);
            end
        end
    end
endmodule

// File: tb/tb_hbm_grp_rd_ctrl.sv
// tb_hbm_grp_rd_ctrl: directed runs with an AXI read responder and a scoreboard monitor.
module tb_hbm_grp_rd_ctrl;
    logic        sclk = 0, rst_n = 0, launch = 0, start_load_all = 0;
    logic [32:0] base_addr = '0;
    logic [15:0] num_burst = '0;
    logic        start_load, busy, done, err;
    logic [31:0] beat_cnt;

    hbm_grp_rd_ctrl_if #(.ADDR_W(33)) axi();

    hbm_grp_rd_ctrl dut (
        .sclk(sclk), .rst_n(rst_n), .launch(launch), .base_addr(base_addr),
        .num_burst(num_burst), .start_load(start_load), .start_load_all(start_load_all),
        .axi(axi), .busy(busy), .done(done), .beat_cnt(beat_cnt), .err(err)
    );

    always #5 sclk = ~sclk;

    typedef struct {logic [31:0] beats; logic err;} done_t;

    int          checks = 0, errors = 0;
    logic [32:0] exp_addr[$];
    done_t       exp_done[$];
    done_t       d_exp;
    int          ar_times[$];
    int          cyc = 0, mout = 0, ar_hs_cnt = 0, sl_cnt = 0, done_cnt = 0, done_base = 0, arms = 0;
    int          rsp_delay = 0, short_beat = -1, bp_left = 0;
    bit          rsp_flush = 0, r_acc = 0, r_acc_last = 0, sl_prev = 0, done_prev = 0, wait_prev = 0;
    logic [32:0] addr_prev = '0;

    function automatic void chk(string n, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", n, got, exp);
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    // Scoreboard monitor: samples mid-cycle, ahead of the edge on which handshakes complete
    always @(negedge sclk) begin
        r_acc      = axi.r_valid & axi.r_ready;
        r_acc_last = r_acc & axi.r_last;
        if (wait_prev) chk("ar_hold", {axi.ar_valid, axi.ar_addr}, {1'b1, addr_prev});
        wait_prev = axi.ar_valid & ~axi.ar_ready;
        addr_prev = axi.ar_addr;
        if (axi.ar_valid & axi.ar_ready) begin
            chk("ar_outstanding_lt8", mout < 8, 1);
            chk("ar_len", axi.ar_len, 63);
            if (exp_addr.size() == 0) chk("ar_extra", exp_addr.size(), 1);
            else chk("ar_addr", axi.ar_addr, exp_addr.pop_front());
            ar_times.push_back(cyc);
            mout++;
            ar_hs_cnt++;
        end
        if (r_acc_last) mout--;
        if (start_load) begin
            chk("start_load_width", sl_prev, 0);
            sl_cnt++;
        end
        sl_prev = start_load;
        if (done) begin
            chk("done_width", done_prev, 0);
            if (exp_done.size() == 0) chk("done_extra", exp_done.size(), 1);
            else begin
                d_exp = exp_done.pop_front();
                chk("done_beat_cnt", beat_cnt, d_exp.beats);
                chk("done_err", err, d_exp.err);
            end
            done_cnt++;
        end
        done_prev = done;
    end

    // In-order read responder: each burst starts rsp_delay cycles after its address handshake
    initial begin
        int beat_i = 0;
        bit act = 0;
        axi.r_valid = 0;
        axi.r_last  = 0;
        forever begin
            @(posedge sclk);
            #1;
            cyc++;
            if (rsp_flush) begin
                ar_times.delete();
                act = 0;
                rsp_flush = 0;
            end else if (r_acc) begin
                if (r_acc_last) begin
                    act = 0;
                    short_beat = -1;
                    void'(ar_times.pop_front());
                end else beat_i++;
            end
            if (!act && ar_times.size() > 0 && cyc >= ar_times[0] + rsp_delay) begin
                act = 1;
                beat_i = 0;
            end
            axi.r_valid = act;
            axi.r_last  = act && beat_i == ((short_beat >= 0) ? short_beat : 63);
        end
    end

    // ar_ready stalls the second request for bp_left cycles
    initial begin
        axi.ar_ready = 1;
        forever begin
            @(posedge sclk);
            #1;
            axi.ar_ready = !(bp_left > 0 && ar_hs_cnt == 1);
            if (!axi.ar_ready) bp_left--;
        end
    end

    task automatic run(input logic [32:0] base, input logic [15:0] nb, input int hold,
                       input logic [31:0] beats, input logic e);
        logic [32:0] a;
        bit anyv;
        launch = 0;
        tick(1);
        base_addr = base;
        num_burst = nb;
        a = {base[32:12], 12'h000};
        for (int i = 0; i < int'(nb); i++) begin
            exp_addr.push_back(a);
            a = a + 33'h1000;
        end
        exp_done.push_back('{beats, e});
        done_base = done_cnt;
        ar_hs_cnt = 0;
        launch = 1;
        tick(1);
        arms++;
        chk("start_load_hi", start_load, 1);
        chk("busy_on_arm", busy, 1);
        tick(1);
        chk("start_load_lo", start_load, 0);
        if (hold > 0) begin
            anyv = 0;
            repeat (hold) begin
                anyv |= axi.ar_valid;
                tick(1);
            end
            chk("hold_no_ar_valid", anyv, 0);
        end
        start_load_all = 1;
        tick(1);
        start_load_all = 0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == done_base && n < budget) begin
            tick(1);
            n++;
        end
        chk("done_seen", done_cnt != done_base, 1);
        tick(2);
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_busy"}, busy, 0);
        chk({n, "_ar"}, {axi.ar_valid, axi.ar_addr, axi.ar_len}, 0);
        chk({n, "_ctl"}, {start_load, axi.r_ready, done, err}, 0);
        chk({n, "_beat_cnt"}, beat_cnt, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        tick(2);
        chk_zero("reset");
        rst_n = 1;
        tick(1);
        // nominal: 0x1_0000_0123 -> 0x1_0000_0000/1000/2000
        run(33'h1_0000_0123, 16'd3, 0, 32'd192, 1'b0);
        wait_done(2000);
        tick(20);
        chk("no_rearm_busy", busy, 0);
        chk("no_rearm_pulses", sl_cnt, arms);
        // backpressure on the second request, addresses wrap past 2^33
        bp_left = 5;
        run(33'h1_FFFF_E456, 16'd3, 0, 32'd192, 1'b0);
        wait_done(2000);
        bp_left = 0;
        // outstanding limit with slow data
        rsp_delay = 100;
        run(33'h0_4000_0000, 16'd20, 0, 32'd1280, 1'b0);
        tick(20);
        chk("max_out_handshakes", ar_hs_cnt, 8);
        chk("max_out_ar_valid", axi.ar_valid, 0);
        wait_done(4000);
        rsp_delay = 0;
        // start_load_all withheld for 50 cycles
        run(33'h0_0000_1000, 16'd2, 50, 32'd128, 1'b0);
        wait_done(1000);
        // zero bursts: done one cycle after start_load_all
        run(33'h0_1234_5678, 16'd0, 0, 32'd0, 1'b0);
        chk("zero_done", done, 1);
        wait_done(10);
        chk("zero_idle", busy, 0);
        // early r_last on beat 10: 11 + 64 beats, err sticky until next arm
        short_beat = 10;
        run(33'h0_0800_0000, 16'd2, 0, 32'd75, 1'b1);
        wait_done(1000);
        tick(5);
        chk("err_sticky", err, 1);
        run(33'h0_0800_0000, 16'd1, 0, 32'd64, 1'b0);
        chk("err_cleared_on_arm", err, 0);
        wait_done(1000);
        // reset in the middle of RUN
        run(33'h1_0000_0000, 16'd4, 0, 32'd256, 1'b0);
        tick(3);
        rst_n = 0;
        launch = 0;
        rsp_flush = 1;
        tick(1);
        chk_zero("midrun_reset");
        rst_n = 1;
        exp_addr.delete();
        exp_done.delete();
        mout = 0;
        tick(2);
        run(33'h1_0000_0000, 16'd2, 0, 32'd128, 1'b0);
        wait_done(1000);
        chk("start_load_pulses", sl_cnt, arms);
        chk("addr_queue_empty", exp_addr.size(), 0);
        chk("done_queue_empty", exp_done.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
